// File: rtl/mc_control_unit.sv
// Multicycle control unit: Moore FSM sequencing, ALU decode,
// flag register and condition-gated architectural writes.
module mc_control_unit #(
  parameter logic [3:0] PC_REG    = 4'd15,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  output logic [2:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic [3:0] flags
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;

  logic [3:0] cmd;
  logic       is_cmp;
  logic [2:0] alu_dec;
  logic [1:0] flag_w;
  logic       cond_pass;
  logic       in_exec;
  logic       rw_int;
  logic       n_f, z_f, c_f, v_f;

  assign cmd     = funct[4:1];
  assign is_cmp  = (cmd == CMD_CMP);
  assign in_exec = (state_q == S_EXECR) ||
                   (state_q == S_EXECI);
  assign {n_f, z_f, c_f, v_f} = flags_q;
  assign flags   = flags_q;

  always_comb begin
    alu_dec = 3'b000;
    flag_w  = 2'b11;
    unique case (1'b1)
      (cmd == CMD_SUB): alu_dec = 3'b001;
      (cmd == CMD_CMP): alu_dec = 3'b001;
      (cmd == CMD_AND): begin
        alu_dec = 3'b010;
        flag_w  = 2'b10;
      end
      (cmd == CMD_ORR): begin
        alu_dec = 3'b011;
        flag_w  = 2'b10;
      end
      default: alu_dec = 3'b000;
    endcase
  end

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = ~z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = ~c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = ~n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = ~v_f;
      4'b1000: cond_pass = c_f & ~z_f;
      4'b1001: cond_pass = ~c_f | z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = ~z_f & (n_f == v_f);
      4'b1101: cond_pass = z_f | (n_f != v_f);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Condition is sampled once per instruction, against DECODE-time flags.
  always_comb begin
    cond_ex_d = cond_ex_q;
    if (state_q == S_DECODE) cond_ex_d = cond_pass;
  end

  always_comb begin
    flags_d = flags_q;
    if (in_exec && funct[0] && cond_ex_q) begin
      if (flag_w[1]) flags_d[3:2] = alu_flags[3:2];
      if (flag_w[0]) flags_d[1:0] = alu_flags[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      flags_q   <= FLAGS_RST;
      cond_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  always_comb begin
    alu_control = 3'b000;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    adr_src     = 1'b0;
    case (state_q)
      S_FETCH, S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR: alu_src_b = 2'b01;
      S_MEMRD:  adr_src = 1'b1;
      S_MEMWB:  result_src = 2'b01;
      S_MEMWR:  adr_src = 1'b1;
      S_EXECR:  alu_control = alu_dec;
      S_EXECI: begin
        alu_src_b   = 2'b01;
        alu_control = alu_dec;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
      end
      default: alu_control = 3'b000;
    endcase
  end

  // Enables are forced low while reset is held, whatever the state.
  assign rw_int = cond_ex_q &
                  ((state_q == S_MEMWB) ||
                   ((state_q == S_ALUWB) && !is_cmp));

  assign reg_write = rst_n & rw_int;
  assign mem_write = rst_n & cond_ex_q &
                     (state_q == S_MEMWR);
  assign ir_write  = rst_n & (state_q == S_FETCH);
  assign pc_write  = rst_n &
                     ((state_q == S_FETCH) ||
                      (cond_ex_q && (state_q == S_BRANCH)) ||
                      (rw_int && (rd == PC_REG)));

endmodule
